ram_dp_sr_bw: RTL and testbench

- Parametrised simple dual-port synchronous RAM: one write port, one independent read port, both on a single clock.
- Successor to the single-port sr/sv RAM:
  - adds per-byte write enables;
  - concurrent read and write;
  - configurable read latency with a valid flag;
  - selectable read-during-write behaviour;
  - the read output holds its last value instead of tri-stating.
- Used as the generic buffer/line-store primitive under accelerator datapaths and FIFOs.

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_rd_pipe.sv | 38 +++
 rtl/ram_dp_sr_bw.sv | 100 ++++++++++
 tb/tb_ram_dp_sr_bw.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and helpers for the dual-port byte-enable RAM
package ram_pkg;
  localparam int RDW_OLD_DATA = 0;
  localparam int RDW_NEW_DATA = 1;
  function automatic int lanes(input int w);
    return w / 8;
  endfunction
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: 1- or 2-stage read register pipeline with async reset and hold-on-idle
//   clk, rst            : clock, async active-high reset
//   in_valid, in_data   : read result entering stage 1 (payload = word plus parity flag)
//   out_valid, out_data : last stage; data holds while no new result arrives
module ram_rd_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [W-1:0]   data_q [LAT];
  logic [W-1:0]   data_d [LAT];
  logic [LAT-1:0] valid_q, valid_d;
  always_comb begin
    data_d[0]  = in_valid ? in_data : data_q[0];
    valid_d[0] = in_valid;
    for (int s = 1; s < LAT; s++) begin
      data_d[s]  = valid_q[s-1] ? data_q[s-1] : data_q[s];
      valid_d[s] = valid_q[s-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign out_data  = data_q[LAT-1];
  assign out_valid = valid_q[LAT-1];
endmodule

// File: rtl/ram_dp_sr_bw.sv
// ram_dp_sr_bw: simple dual-port sync RAM with byte enables, 1/2-cycle read latency, selectable read-during-write
//   wr_en/wr_addr/wr_be/wr_data : write port, per-byte enables
//   rd_en/rd_addr               : read port
//   rd_data/rd_valid            : registered read result, held while idle
//   rd_perr                     : lane parity error, only when RAM_PARITY_EN is defined
module ram_dp_sr_bw
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
`ifdef RAM_PARITY_EN
  ,output logic                   rd_perr
`endif
);
  localparam int NB = lanes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
`ifdef RAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  if (DATA_WIDTH % 8 != 0) begin : g_chk_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
    $error("RD_LATENCY must be 1 or 2");
  end
  if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_chk_depth
    $error("RAM_DEPTH exceeds 2**ADDR_WIDTH");
  end
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic                  wr_ok, rd_ok, hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH+PW-1:0] pipe_in, pipe_out;
  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH);
  assign rd_ok = {1'b0, rd_addr} < DEPTH;
  assign hit   = wr_ok && rd_ok && (wr_addr == rd_addr) && (RDW_MODE == RDW_NEW_DATA);
`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_q [RAM_DEPTH];
  logic [NB-1:0] rd_par;
  logic          perr_raw, perr_o;
  always_ff @(posedge clk) begin
    if (wr_ok)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) begin
          mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
          par_q[wr_addr][i]        <= par8(wr_data[8*i +: 8]);
        end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_ok)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  end
`endif
  // Out-of-range reads return zero; NEW_DATA bypass overlays only the enabled lanes.
  always_comb begin
    rd_word = rd_ok ? mem_q[rd_addr] : '0;
    for (int i = 0; i < NB; i++)
      if (hit && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
  end
`ifdef RAM_PARITY_EN
  // Bypassed lanes carry fresh data and are never flagged; zeroed out-of-range words have matching zero parity.
  always_comb begin
    rd_par   = rd_ok ? par_q[rd_addr] : '0;
    perr_raw = 1'b0;
    for (int i = 0; i < NB; i++)
      perr_raw = perr_raw | (!(hit && wr_be[i]) && (par8(rd_word[8*i +: 8]) != rd_par[i]));
  end
  assign pipe_in = {perr_raw, rd_word};
  assign {perr_o, rd_data} = pipe_out;
  assign rd_perr = perr_o & rd_valid;
`else
  assign pipe_in = rd_word;
  assign rd_data = pipe_out;
`endif
  ram_rd_pipe #(.W(DATA_WIDTH + PW), .LAT(RD_LATENCY)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   (pipe_in),
    .out_valid (rd_valid),
    .out_data  (pipe_out)
  );
endmodule

// File: tb/tb_ram_dp_sr_bw.sv
// tb_ram_dp_sr_bw: directed table-driven bench for two RAM configurations sharing one stimulus stream
module tb_ram_dp_sr_bw;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0]  wr_addr = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid;
  int          n_pass = 0, n_tot = 0;
`ifdef RAM_PARITY_EN
  logic        a_perr, b_perr;
`endif
  always #5 clk = ~clk;

  ram_dp_sr_bw dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid)
`ifdef RAM_PARITY_EN
    , .rd_perr(a_perr)
`endif
  );
  ram_dp_sr_bw #(.RAM_DEPTH(200), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid)
`ifdef RAM_PARITY_EN
    , .rd_perr(b_perr)
`endif
  );

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic        av;
    logic [31:0] ad;
    logic        bv;
    logic [31:0] bd;
  } vec_t;
  vec_t v [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic we, input logic [7:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [7:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  initial begin
    v[0]  = '{1'b1, 8'd5,   4'hF, 32'h11223344, 1'b0, 8'd0,   1'b0, 32'h0,        1'b0, 32'h0};
    v[1]  = '{1'b1, 8'd5,   4'h5, 32'hAABBCCDD, 1'b0, 8'd0,   1'b0, 32'h0,        1'b0, 32'h0};
    v[2]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   1'b1, 32'h11BB33DD, 1'b0, 32'h0};
    v[3]  = '{1'b1, 8'd9,   4'hF, 32'h0,        1'b0, 8'd0,   1'b0, 32'h11BB33DD, 1'b1, 32'h11BB33DD};
    v[4]  = '{1'b1, 8'd9,   4'hF, 32'hDEADBEEF, 1'b1, 8'd9,   1'b1, 32'h0,        1'b0, 32'h11BB33DD};
    v[5]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
    v[6]  = '{1'b1, 8'd9,   4'h3, 32'h12345678, 1'b1, 8'd9,   1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    v[7]  = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b0, 32'hDEADBEEF, 1'b1, 32'hDEAD5678};
    v[8]  = '{1'b1, 8'd250, 4'hF, 32'h55,       1'b0, 8'd0,   1'b0, 32'hDEADBEEF, 1'b0, 32'hDEAD5678};
    v[9]  = '{1'b1, 8'd199, 4'hF, 32'hCAFEF00D, 1'b0, 8'd0,   1'b0, 32'hDEADBEEF, 1'b0, 32'hDEAD5678};
    v[10] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd250, 1'b1, 32'h55,       1'b0, 32'hDEAD5678};
    v[11] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd199, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0};
    v[12] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
    v[13] = '{1'b1, 8'd199, 4'h0, 32'h0,        1'b0, 8'd0,   1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    v[14] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd199, 1'b1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    v[15] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
    v[16] = '{1'b1, 8'd5,   4'hF, 32'hFFFFFFFF, 1'b1, 8'd199, 1'b1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    v[17] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b1, 8'd5,   1'b1, 32'hFFFFFFFF, 1'b1, 32'hCAFEF00D};
    v[18] = '{1'b0, 8'd0,   4'h0, 32'h0,        1'b0, 8'd0,   1'b0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};

    #1;
    chk("reset a_data", a_data, 32'h0);
    chk("reset a_valid", 32'(a_valid), 32'h0);
    chk("reset b_data", b_data, 32'h0);
    chk("reset b_valid", 32'(b_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(v[i].we, v[i].wa, v[i].be, v[i].wd, v[i].re, v[i].ra);
      @(negedge clk);
      chk($sformatf("vec%0d a_valid", i), 32'(a_valid), 32'(v[i].av));
      chk($sformatf("vec%0d a_data", i), a_data, v[i].ad);
      chk($sformatf("vec%0d b_valid", i), 32'(b_valid), 32'(v[i].bv));
      chk($sformatf("vec%0d b_data", i), b_data, v[i].bd);
    end

    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'(k), 4'hF, 32'(k), 1'b0, 8'd0);
      @(negedge clk);
    end
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'(c));
      else drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0);
      @(negedge clk);
      chk($sformatf("stream%0d a_valid", c), 32'(a_valid), 32'(c < 8));
      chk($sformatf("stream%0d a_data", c), a_data, (c < 8) ? 32'(c) : 32'd7);
      chk($sformatf("stream%0d b_valid", c), 32'(b_valid), 32'(c >= 1 && c <= 8));
      if (c >= 1) chk($sformatf("stream%0d b_data", c), b_data, (c <= 8) ? 32'(c - 1) : 32'd7);
    end

    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd3);
    @(posedge clk);
    #2;
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0);
    chk("pre-rst a_valid", 32'(a_valid), 32'h1);
    chk("pre-rst a_data", a_data, 32'h3);
    rst = 1'b1;
    #1;
    chk("async rst a_data", a_data, 32'h0);
    chk("async rst a_valid", 32'(a_valid), 32'h0);
    chk("async rst b_data", b_data, 32'h0);
    chk("async rst b_valid", 32'(b_valid), 32'h0);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst%0d a_valid", c), 32'(a_valid), 32'h0);
      chk($sformatf("post-rst%0d b_valid", c), 32'(b_valid), 32'h0);
      chk($sformatf("post-rst%0d b_data", c), b_data, 32'h0);
    end
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd2);
    @(negedge clk);
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0);
    chk("after-rst a_data", a_data, 32'h2);
    @(negedge clk);
    chk("after-rst b_valid", 32'(b_valid), 32'h1);
    chk("after-rst b_data", b_data, 32'h2);

`ifdef RAM_PARITY_EN
    drive(1'b1, 8'd3, 4'hF, 32'h000000FF, 1'b0, 8'd0);
    @(negedge clk);
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0);
    force dut_a.mem_q[3] = 32'h000000FE;
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd3);
    @(negedge clk);
    chk("perr inject valid", 32'(a_valid), 32'h1);
    chk("perr inject flag", 32'(a_perr), 32'h1);
    release dut_a.mem_q[3];
    drive(1'b1, 8'd3, 4'hF, 32'h000000FF, 1'b0, 8'd0);
    @(negedge clk);
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd3);
    @(negedge clk);
    drive(1'b0, 8'd0, 4'h0, 32'h0, 1'b0, 8'd0);
    chk("perr clean data", a_data, 32'h000000FF);
    chk("perr clean flag", 32'(a_perr), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
